// File: rtl/div_ctrl.sv
// Multi-cycle restoring divide sequencer for DIV/DIVU in the EX stage.
// It latches the operands on start, runs DATA_W shift/subtract steps, then returns {remainder, quotient}.
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvd;   // holds the dividend, then shifts in quotient bits
  logic [DATA_W-1:0] dvs;
  logic              sign_q;
  logic              sign_r;

  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W:0]   partial;
  logic [DATA_W-1:0] trial;
  logic              fits;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

  // The shifted remainder needs DATA_W+1 bits so unsigned divisors above 2^(DATA_W-1) compare correctly.
  assign partial = {rem, dvd[DATA_W-1]};
  assign fits    = partial >= {1'b0, dvs};
  assign trial   = partial[DATA_W-1:0] - dvs;

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state  <= ON;
              cnt    <= '0;
              rem    <= '0;
              dvd    <= op1_neg ? (DATA_W'(0) - opdata1_i) : opdata1_i;
              dvs    <= op2_neg ? (DATA_W'(0) - opdata2_i) : opdata2_i;
              sign_q <= op1_neg ^ op2_neg;
              sign_r <= op1_neg;
            end
          end
        end

        BYZERO: begin
          state    <= END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end

        ON: begin
          if (annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            rem <= fits ? trial : partial[DATA_W-1:0];
            dvd <= {dvd[DATA_W-2:0], fits};
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {sign_r ? (DATA_W'(0) - rem) : rem,
                         sign_q ? (DATA_W'(0) - dvd) : dvd};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end

        END: begin
          if (!start_i || annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, signed/unsigned results, divide by zero,
// annul, reset mid-operation, operand changes and holding in END.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_checks = 0;
  int n_fails  = 0;

  div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sets operands, raises start and advances through the start edge.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
  endtask

  // Counts edges until ready rises; gives up after 40 so a hung DUT still reaches the summary.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_op();
    start = 1'b0;
    tick();
    check("release_ready", 64'(ready), 64'd0);
    check("release_result", result, 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] held;
    rst        = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) tick();
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_stall", 64'(stallreq), 64'd0);
    rst = 1'b1;
    tick();

    // Unsigned 100 / 7: stall held for every step, ready exactly 33 edges after start.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    #1;
    check("udiv_stall_pre", 64'(stallreq), 64'd1);
    tick();
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("udiv_busy_ready", 64'(ready), 64'd0);
      check("udiv_busy_stall", 64'(stallreq), 64'd1);
    end
    tick();
    check("udiv_ready", 64'(ready), 64'd1);
    check("udiv_result", result, 64'h00000002_0000000E);
    check("udiv_stall_done", 64'(stallreq), 64'd0);
    finish_op();

    // Signed -7 / 2 -> q = -3, r = -1.
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(n);
    check("sdiv_lat", 64'(n), 64'd33);
    check("sdiv_result", result, 64'hFFFFFFFF_FFFFFFFD);
    finish_op();

    // Signed 7 / -2 -> q = -3, r = 1.
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(n);
    check("sdiv2_result", result, 64'h00000001_FFFFFFFD);
    finish_op();

    // Signed overflow case wraps without trap.
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(n);
    check("ovf_lat", 64'(n), 64'd33);
    check("ovf_result", result, 64'h00000000_80000000);
    finish_op();

    // Unsigned with large operands exercises the wide trial subtract.
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_ready(n);
    check("ubig_result", result, 64'h00000000_FFFFFFFF);
    finish_op();
    launch(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_ready(n);
    check("ubig2_result", result, 64'hFFFFFFFE_00000000);
    finish_op();

    // Divide by zero: ready two edges after start is driven, result zero.
    launch(1'b0, 32'd55, 32'd0);
    check("dbz_ready_early", 64'(ready), 64'd0);
    tick();
    check("dbz_ready", 64'(ready), 64'd1);
    check("dbz_result", result, 64'd0);
    check("dbz_stall", 64'(stallreq), 64'd0);
    finish_op();
    check("dbz_stall_free", 64'(stallreq), 64'd0);

    // Annul at step 10, then start+annul together must not start, then 9 / 3.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) tick();
    annul = 1'b1;
    #1;
    check("annul_stall", 64'(stallreq), 64'd0);
    tick();
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    opdata1 = 32'd9;
    opdata2 = 32'd3;
    tick();
    check("annul_nostart", 64'(ready), 64'd0);
    annul = 1'b0;
    tick();
    wait_ready(n);
    check("annul_restart_lat", 64'(n), 64'd33);
    check("annul_restart_result", result, 64'h00000000_00000003);
    finish_op();

    // Operand change mid-divide is ignored: 1000 / 7 -> q 142, r 6.
    launch(1'b0, 32'd1000, 32'd7);
    repeat (5) tick();
    opdata1    = 32'd5;
    opdata2    = 32'd1;
    signed_div = 1'b1;
    wait_ready(n);
    check("opchg_lat", 64'(n), 64'd28);
    check("opchg_result", result, 64'h00000006_0000008E);
    finish_op();

    // Reset at step 20 abandons the divide; a restart of 50 / 5 completes normally.
    launch(1'b0, 32'd100, 32'd7);
    repeat (20) tick();
    rst = 1'b0;
    tick();
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    rst     = 1'b1;
    tick();
    wait_ready(n);
    check("rst_restart_lat", 64'(n), 64'd33);
    check("rst_restart_result", result, 64'h00000000_0000000A);

    // Hold in END while start stays high; then drop and re-raise for a fresh operation.
    held = result;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, held);
    end
    start = 1'b0;
    tick();
    check("hold_drop_ready", 64'(ready), 64'd0);
    launch(1'b0, 32'd50, 32'd5);
    wait_ready(n);
    check("hold_restart_lat", 64'(n), 64'd33);
    check("hold_restart_result", result, 64'h00000000_0000000A);
    finish_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle 32-bit divide sequencer for the EX stage, serving DIV/DIVU.
- It latches the two operands produced by decode, runs a 32-step restoring division, and returns {remainder, quotient} for the HI/LO write.
- It raises a stall request so that the pipeline controller holds IF/ID/EX until the result is ready.
- EX can annul an in-flight divide, e.g. on a flush.

Parameters:
- DATA_W, 32, operand width; the step count equals DATA_W.
- CNT_W, 6, width of the step counter; must hold the value DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  in  32  dividend; sampled with start_i.
- opdata2_i  in  32  divisor; sampled with start_i.
- start_i  in  1  divide request from EX; held high until the result is consumed.
- annul_i  in  1  cancel the current operation.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  result_o valid; registered.
- stallreq_o  out  1  pipeline hold request; combinational.

Behaviour:
- States: FREE, BYZERO, ON, END. Reset state is FREE.
- Outputs while rst=0: result_o=0, ready_o=0, counter=0. Reset mid-operation abandons the divide with no residue.
- stallreq_o = start_i & ~annul_i & ~ready_o.

FREE:
- If start_i=1 and annul_i=0, latch signed_div_i and the operands.
- If the divisor is 0, go to BYZERO.
- Otherwise go to ON with cnt=0. Load the working dividend with abs(op1) and the working divisor with abs(op2) when signed, raw values when unsigned.
- Record sign_q = op1[31]^op2[31] and sign_r = op1[31], both forced to 0 when unsigned.
- Otherwise remain in FREE with ready_o=0 and result_o=0.

BYZERO:
- Next edge: go to END with result_o=0 and ready_o=1.

ON, annul_i=1:
- Go to FREE immediately. ready_o stays 0 and result_o=0.

ON, cnt<32:
- Perform one restoring step: shift {rem, dividend} left by 1 and trial-subtract the divisor from rem[31:0]. If there is no borrow, rem takes the difference and the quotient bit is 1; otherwise the quotient bit is 0.
- cnt increments.

ON, cnt==32:
- Negate the quotient if sign_q=1 and the remainder if sign_r=1 (two's complement, mod 2^32).
- Load result_o, set ready_o=1, go to END.

END:
- Hold result_o and ready_o while start_i=1.
- When start_i=0, go to FREE, clearing ready_o and result_o on the same edge.
- annul_i in END also returns to FREE.

Latency and input handling:
- Start sampled at edge N gives ready_o=1 after edge N+33.
- A divide by zero gives ready_o=1 after edge N+1.
- Operand or mode changes after the start edge are ignored until the next FREE.
- Overflow 0x80000000 / 0xFFFFFFFF (signed) gives q=0x80000000, r=0, with no trap.
- start_i and annul_i both high in FREE: no start.

Test Plan:
- Unsigned: op1=100, op2=7, signed=0, start held → ready_o rises 33 cycles after the start edge; result_o=64'h00000002_0000000E. stallreq_o=1 throughout, 0 once ready_o=1.
- Signed: op1=-7 (0xFFFFFFF9), op2=2 → result_o=64'hFFFFFFFF_FFFFFFFD (r=-1, q=-3). Also signed 0x80000000 / 0xFFFFFFFF → result_o=64'h00000000_80000000.
- Divide by zero: op2=0 → ready_o=1 two edges after start with result_o=0. Drop start_i → next edge ready_o=0, state FREE.
- Annul: assert annul_i at step 10 → next edge FREE, ready_o stays 0, stallreq_o=0. A new start of 9/3 then yields q=3, r=0 after 33 cycles.
- Operand change and reset: change opdata1_i mid-divide → result unaffected. Pull rst low at step 20 → result_o=0, ready_o=0, FREE. A restart completes normally.
- Hold in END: keep start_i high 5 cycles after ready → result_o stable, no restart. Drop start_i and re-raise it the following cycle → a new 33-cycle operation.
